vga_sync_gen: RTL and testbench

//   Produces the VGA raster timing consumed by the text overlay, graphics and RGB mux:
//   the pixel-enable tick, the current pixel coordinate x/y, hsync/vsync, video_on and
//   a once-per-frame tick. It divides the system clock down to the pixel rate and runs
//   the horizontal and vertical counters, so every downstream renderer sees the same

---
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate enable, x/y raster counters, registered sync pulses,
// visible-area flag and an end-of-frame strobe shared by every downstream renderer.
module vga_sync_gen #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_tick
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_STOP  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_STOP  = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be in 1..16");
   end

   // With no division every system clock is a pixel clock, so no counter exists.
   if (CLK_DIV == 1) begin : g_nodiv
      assign p_tick = 1'b1;
   end else begin : g_div
      logic [DIV_W-1:0] div_q, div_d;

      always_comb begin
         div_d = div_q + 1'b1;
         if (div_q == DIV_W'(CLK_DIV - 1)) div_d = '0;
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) div_q <= '0;
         else          div_q <= div_d;
      end

      assign p_tick = (div_q == DIV_W'(CLK_DIV - 1));
   end

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       line_end;

   assign line_end = p_tick && (x_q == H_LAST);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (p_tick) begin
         x_d = (x_q == H_LAST) ? '0 : x_q + 10'd1;
      end
      if (line_end) begin
         y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end
   end

   // Syncs are decoded from the next counter values so they switch on the same edge as x/y.
   always_comb begin
      hsync_d = !(({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_STOP));
      vsync_d = !(({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_STOP));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
   assign frame_tick = line_end && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: four differently-parameterised instances compared every clock
// against an arithmetic raster model indexed by clocks elapsed since reset release.
module tb_vga_sync_gen;

   typedef struct packed {
      int unsigned div;
      int unsigned hd, hf, hs, hb;
      int unsigned vd, vf, vs, vb;
   } cfg_t;

   typedef struct packed {
      logic       p;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       von;
      logic       ft;
   } exp_t;

   localparam cfg_t CA = '{div:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
   localparam cfg_t CB = '{div:2, hd:8,   hf:1,  hs:2,  hb:1,  vd:4,   vf:1,  vs:2, vb:1};
   localparam cfg_t CC = '{div:1, hd:10,  hf:2,  hs:3,  hb:1,  vd:5,   vf:1,  vs:1, vb:2};
   localparam cfg_t CD = '{div:3, hd:20,  hf:3,  hs:4,  hb:5,  vd:6,   vf:2,  vs:3, vb:1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c, rst_d;
   logic pA, hsA, vsA, vonA, ftA; logic [9:0] xA, yA;
   logic pB, hsB, vsB, vonB, ftB; logic [9:0] xB, yB;
   logic pC, hsC, vsC, vonC, ftC; logic [9:0] xC, yC;
   logic pD, hsD, vsD, vonD, ftD; logic [9:0] xD, yD;

   vga_sync_gen #(.CLK_DIV(CA.div), .H_DISPLAY(CA.hd), .H_FRONT(CA.hf), .H_SYNC(CA.hs),
      .H_BACK(CA.hb), .V_DISPLAY(CA.vd), .V_FRONT(CA.vf), .V_SYNC(CA.vs), .V_BACK(CA.vb))
   u_a (.clk(clk), .reset_n(rst_a), .p_tick(pA), .x(xA), .y(yA), .hsync(hsA),
        .vsync(vsA), .video_on(vonA), .frame_tick(ftA));

   vga_sync_gen #(.CLK_DIV(CB.div), .H_DISPLAY(CB.hd), .H_FRONT(CB.hf), .H_SYNC(CB.hs),
      .H_BACK(CB.hb), .V_DISPLAY(CB.vd), .V_FRONT(CB.vf), .V_SYNC(CB.vs), .V_BACK(CB.vb))
   u_b (.clk(clk), .reset_n(rst_b), .p_tick(pB), .x(xB), .y(yB), .hsync(hsB),
        .vsync(vsB), .video_on(vonB), .frame_tick(ftB));

   vga_sync_gen #(.CLK_DIV(CC.div), .H_DISPLAY(CC.hd), .H_FRONT(CC.hf), .H_SYNC(CC.hs),
      .H_BACK(CC.hb), .V_DISPLAY(CC.vd), .V_FRONT(CC.vf), .V_SYNC(CC.vs), .V_BACK(CC.vb))
   u_c (.clk(clk), .reset_n(rst_c), .p_tick(pC), .x(xC), .y(yC), .hsync(hsC),
        .vsync(vsC), .video_on(vonC), .frame_tick(ftC));

   vga_sync_gen #(.CLK_DIV(CD.div), .H_DISPLAY(CD.hd), .H_FRONT(CD.hf), .H_SYNC(CD.hs),
      .H_BACK(CD.hb), .V_DISPLAY(CD.vd), .V_FRONT(CD.vf), .V_SYNC(CD.vs), .V_BACK(CD.vb))
   u_d (.clk(clk), .reset_n(rst_d), .p_tick(pD), .x(xD), .y(yD), .hsync(hsD),
        .vsync(vsD), .video_on(vonD), .frame_tick(ftD));

   int checks = 0;
   int failures = 0;
   logic run = 1'b0;

   // Clocks elapsed since each reset release; the raster position is pure arithmetic on this.
   longint tA, tB, tC, tD;
   always @(posedge clk or negedge rst_a) if (!rst_a) tA <= 0; else tA <= tA + 1;
   always @(posedge clk or negedge rst_b) if (!rst_b) tB <= 0; else tB <= tB + 1;
   always @(posedge clk or negedge rst_c) if (!rst_c) tC <= 0; else tC <= tC + 1;
   always @(posedge clk or negedge rst_d) if (!rst_d) tD <= 0; else tD <= tD + 1;

   function automatic exp_t model(input cfg_t c, input longint t);
      longint ht, vt, n, xx, yy, hs0, vs0;
      exp_t e;
      ht  = longint'(c.hd + c.hf + c.hs + c.hb);
      vt  = longint'(c.vd + c.vf + c.vs + c.vb);
      hs0 = longint'(c.hd + c.hf);
      vs0 = longint'(c.vd + c.vf);
      n   = t / longint'(c.div);
      xx  = n % ht;
      yy  = (n / ht) % vt;
      e.p   = ((t % longint'(c.div)) == longint'(c.div) - 1);
      e.x   = 10'(xx);
      e.y   = 10'(yy);
      e.hs  = !(xx >= hs0 && xx < hs0 + longint'(c.hs));
      e.vs  = !(yy >= vs0 && yy < vs0 + longint'(c.vs));
      e.von = (xx < longint'(c.hd)) && (yy < longint'(c.vd));
      e.ft  = e.p && (xx == ht - 1) && (yy == vt - 1);
      return e;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e, input exp_t a);
      chk({tag, ".p_tick"},     longint'(a.p),   longint'(e.p));
      chk({tag, ".x"},          longint'(a.x),   longint'(e.x));
      chk({tag, ".y"},          longint'(a.y),   longint'(e.y));
      chk({tag, ".hsync"},      longint'(a.hs),  longint'(e.hs));
      chk({tag, ".vsync"},      longint'(a.vs),  longint'(e.vs));
      chk({tag, ".video_on"},   longint'(a.von), longint'(e.von));
      chk({tag, ".frame_tick"}, longint'(a.ft),  longint'(e.ft));
   endtask

   // Literal reset values, checked while reset is held low between clock edges.
   task automatic chk_reset(input string tag, input exp_t a, input logic p_exp);
      exp_t r;
      r = '{p:p_exp, x:10'd0, y:10'd0, hs:1'b1, vs:1'b1, von:1'b1, ft:1'b0};
      chk_all({tag, ".rst"}, r, a);
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk_all("A", model(CA, tA), {pA, xA, yA, hsA, vsA, vonA, ftA});
         chk_all("B", model(CB, tB), {pB, xB, yB, hsB, vsB, vonB, ftB});
         chk_all("C", model(CC, tC), {pC, xC, yC, hsC, vsC, vonC, ftC});
         chk_all("D", model(CD, tD), {pD, xD, yD, hsD, vsD, vonD, ftD});
         if (rst_a) begin
            if (tA == 2)    chk("A.pin_ptick_t2", longint'(pA), 0);
            if (tA == 3)    chk("A.pin_ptick_t3", longint'(pA), 1);
            if (tA == 4)    chk("A.pin_x_t4", longint'(xA), 1);
            if (tA == 7)    chk("A.pin_ptick_t7", longint'(pA), 1);
            if (tA == 2559) chk("A.pin_von_x639", longint'(vonA), 1);
            if (tA == 2560) chk("A.pin_von_x640", longint'(vonA), 0);
            if (tA == 2623) chk("A.pin_hs_x655", longint'(hsA), 1);
            if (tA == 2624) chk("A.pin_hs_x656", longint'(hsA), 0);
            if (tA == 3007) chk("A.pin_hs_x751", longint'(hsA), 0);
            if (tA == 3008) chk("A.pin_hs_x752", longint'(hsA), 1);
            if (tA == 3199) chk("A.pin_x799", longint'(xA), 799);
            if (tA == 3200) chk("A.pin_wrap_x", longint'(xA), 0);
            if (tA == 3200) chk("A.pin_wrap_y", longint'(yA), 1);
         end
         if (rst_b) begin
            if (tB == 17) chk("B.pin_hs_x8", longint'(hsB), 1);
            if (tB == 18) chk("B.pin_hs_x9", longint'(hsB), 0);
            if (tB == 21) chk("B.pin_hs_x10", longint'(hsB), 0);
            if (tB == 22) chk("B.pin_hs_x11", longint'(hsB), 1);
            if (tB == 24) chk("B.pin_line_y", longint'(yB), 1);
         end
         if (rst_c && tC == 5) chk("C.pin_x_t5", longint'(xC), 5);
         if (rst_d) begin
            if (tD == 767)  chk("D.pin_vs_y7", longint'(vsD), 1);
            if (tD == 768)  chk("D.pin_vs_y8", longint'(vsD), 0);
            if (tD == 1055) chk("D.pin_vs_y10", longint'(vsD), 0);
            if (tD == 1056) chk("D.pin_vs_y11", longint'(vsD), 1);
            if (tD == 1150) chk("D.pin_ft_t1150", longint'(ftD), 0);
            if (tD == 1151) chk("D.pin_ft_t1151", longint'(ftD), 1);
         end
      end
   end

   initial begin
      bit hit;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
      run = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      chk_reset("A", {pA, xA, yA, hsA, vsA, vonA, ftA}, 1'b0);
      chk_reset("C", {pC, xC, yC, hsC, vsC, vonC, ftC}, 1'b1);
      #1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
      repeat (3400) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         int unsigned k;
         repeat ($urandom_range(30, 300)) @(negedge clk);
         k = $urandom_range(1, 3);
         #2;
         case (k)
            1: rst_b = 1'b0;
            2: rst_c = 1'b0;
            default: rst_d = 1'b0;
         endcase
         #1;
         case (k)
            1: chk_reset("B", {pB, xB, yB, hsB, vsB, vonB, ftB}, 1'b0);
            2: chk_reset("C", {pC, xC, yC, hsC, vsC, vonC, ftC}, 1'b1);
            default: chk_reset("D", {pD, xD, yD, hsD, vsD, vonD, ftD}, 1'b0);
         endcase
         repeat ($urandom_range(1, 4)) @(negedge clk);
         #2;
         rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
      end

      hit = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (tA >= 3200 && (tA % 3200) == 1200) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) begin
         chk("A.midline_wait_timeout", 0, 1);
      end else begin
         chk("A.midline_x", longint'(xA), 300);
         #2 rst_a = 1'b0;
         #1 chk_reset("A.midline", {pA, xA, yA, hsA, vsA, vonA, ftA}, 1'b0);
         repeat (3) @(negedge clk);
         #2 rst_a = 1'b1;
      end
      repeat (40) @(negedge clk);
      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
